// File: rtl/dmem_lsu.sv
// -----------------------------------------------------------------------------
// dmem_lsu
// Data memory with an integrated load/store unit for the MEM stage.
// Byte, halfword and word accesses on a byte address, with byte-lane write
// enables and sign/zero-extended loads. Misaligned or reserved-size accesses
// are rejected. Load data is registered: one cycle of latency. After reset the
// array is optionally zeroed, one word per cycle, before requests are accepted.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   ready        high once the block accepts requests
//   req          access request
//   we           1 = store, 0 = load
//   size         00 byte, 01 half, 10 word, 11 reserved (always rejected)
//   unsigned_ld  1 = zero-extend loads, 0 = sign-extend
//   addr         byte address, word index addr[AW-1:2], offset addr[1:0]
//   wdata        right-aligned store data
//   rdata        registered load result (holds while rvalid=0)
//   rvalid       one-cycle load-response pulse
//   err          one-cycle rejected-access pulse
// -----------------------------------------------------------------------------
module dmem_lsu #(
  parameter int DEPTH          = 128,
  parameter int AW             = 9,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  output logic          ready,
  input  logic          req,
  input  logic          we,
  input  logic [1:0]    size,
  input  logic          unsigned_ld,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  output logic          rvalid,
  output logic          err
);

  localparam int IW = AW - 2;

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_e;

  localparam state_e RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

  state_e          state_q, state_d;
  logic [IW-1:0]   clr_cnt_q, clr_cnt_d;
  logic            rvalid_q, rvalid_d;
  logic            err_q, err_d;
  logic [31:0]     rdata_q, rdata_d;

  logic [31:0]     mem [DEPTH];

  // Request decode
  logic [IW-1:0]   idx;
  logic [1:0]      off;
  logic            accept;
  logic            bad;

  // Array write port (shared by the clear sweep and stores)
  logic            wr_en;
  logic [IW-1:0]   wr_idx;
  logic [3:0]      wr_be;
  logic [31:0]     wr_data;

  // Load extraction
  logic [31:0]     rd_word;
  logic [7:0]      rd_byte;
  logic [15:0]     rd_half;
  logic [31:0]     ld_result;

  assign idx    = addr[AW-1:2];
  assign off    = addr[1:0];
  assign ready  = (state_q == ST_RUN);
  assign accept = req & ready;

  always_comb begin
    unique case (size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = off[0];
      2'b10:   bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
  end

  // Array is read asynchronously so that a store at edge N is visible to a
  // load accepted at edge N+1 without any forwarding path.
  assign rd_word = mem[idx];
  assign rd_byte = rd_word[{off, 3'b000} +: 8];
  assign rd_half = off[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    unique case (size)
      2'b00:   ld_result = unsigned_ld ? {24'h0, rd_byte}
                                       : {{24{rd_byte[7]}}, rd_byte};
      2'b01:   ld_result = unsigned_ld ? {16'h0, rd_half}
                                       : {{16{rd_half[15]}}, rd_half};
      default: ld_result = rd_word;
    endcase
  end

  // Next-state, clear sweep, write port and response logic.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    wr_en     = 1'b0;
    wr_idx    = idx;
    wr_be     = 4'h0;
    wr_data   = 32'h0;
    rvalid_d  = 1'b0;
    err_d     = 1'b0;
    rdata_d   = rdata_q;

    unique case (state_q)
      ST_CLEAR: begin
        wr_en     = 1'b1;
        wr_idx    = clr_cnt_q;
        wr_be     = 4'hF;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == IW'(DEPTH - 1)) begin
          state_d   = ST_RUN;
          clr_cnt_d = '0;
        end
      end
      default: begin
        if (accept) begin
          err_d = bad;
          if (we) begin
            if (!bad) begin
              wr_en = 1'b1;
              unique case (size)
                2'b00: begin
                  wr_be   = 4'b0001 << off;
                  wr_data = {4{wdata[7:0]}};
                end
                2'b01: begin
                  wr_be   = off[1] ? 4'b1100 : 4'b0011;
                  wr_data = {2{wdata[15:0]}};
                end
                default: begin
                  wr_be   = 4'hF;
                  wr_data = wdata;
                end
              endcase
            end
          end else begin
            rvalid_d = 1'b1;
            rdata_d  = bad ? 32'h0 : ld_result;
          end
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RESET_STATE;
      clr_cnt_q <= '0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= 32'h0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  // NOTE: the array has no reset branch; it maps onto RAM that cannot be
  // reset in one cycle, so zeroing is done by the clear sweep instead.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  assign rvalid = rvalid_q;
  assign err    = err_q;
  assign rdata  = rdata_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// -----------------------------------------------------------------------------
// tb_dmem_lsu
// Directed bench for dmem_lsu (DEPTH=128, AW=9, CLEAR_ON_RESET=1). Each
// accepted request pushes its expected response onto a scoreboard queue; the
// entry is popped and compared one cycle later when the DUT responds.
// -----------------------------------------------------------------------------
module tb_dmem_lsu;

  localparam int DEPTH = 128;
  localparam int AW    = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          ready;
  logic          req;
  logic          we;
  logic [1:0]    size;
  logic          unsigned_ld;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          rvalid;
  logic          err;

  typedef struct packed {
    logic        rvalid;
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  resp_t       sb[$];
  logic [31:0] last_rdata;
  int          checks = 0;
  int          errors = 0;

  dmem_lsu #(.DEPTH(DEPTH), .AW(AW), .CLEAR_ON_RESET(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .ready       (ready),
    .req         (req),
    .we          (we),
    .size        (size),
    .unsigned_ld (unsigned_ld),
    .addr        (addr),
    .wdata       (wdata),
    .rdata       (rdata),
    .rvalid      (rvalid),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive a request, push its expected response if the bench
  // expects it to be accepted, then compare outputs just after the edge.
  task automatic step(input string tag, input logic r, input logic w,
                      input logic [1:0] sz, input logic u,
                      input logic [AW-1:0] a, input logic [31:0] wd,
                      input logic acc, input logic [31:0] exp_data);
    logic  rej;
    resp_t e;
    rej = (sz == 2'b11) || (sz == 2'b01 && a[0]) ||
          (sz == 2'b10 && a[1:0] != 2'b00);
    req = r; we = w; size = sz; unsigned_ld = u; addr = a; wdata = wd;
    if (r && acc) begin
      if (w) begin
        sb.push_back({1'b0, rej, last_rdata});
      end else begin
        last_rdata = rej ? 32'h0 : exp_data;
        sb.push_back({1'b1, rej, last_rdata});
      end
    end
    @(posedge clk);
    #1;
    req = 1'b0;
    if (sb.size() > 0) e = sb.pop_front();
    else               e = {1'b0, 1'b0, last_rdata};
    check({tag, ".rvalid"}, {31'h0, rvalid}, {31'h0, e.rvalid});
    check({tag, ".err"},    {31'h0, err},    {31'h0, e.err});
    check({tag, ".rdata"},  rdata,           e.rdata);
  endtask

  // Counts rising edges until ready is seen, with a hard budget.
  task automatic wait_ready(input string tag, output int n,
                            output logic pulse);
    n = 0;
    pulse = 1'b0;
    while (n < 300) begin
      @(posedge clk);
      #1;
      n++;
      if (rvalid || err) pulse = 1'b1;
      if (ready) break;
    end
    req = 1'b0;
    check({tag, ".clear_cycles"}, n, DEPTH);
    check({tag, ".no_pulse"}, {31'h0, pulse}, 32'h0);
  endtask

  initial begin
    int   n;
    logic pulse;

    rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'b10; unsigned_ld = 1'b0;
    addr = '0; wdata = 32'h0; last_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.ready",  {31'h0, ready},  32'h0);
    check("rst.rvalid", {31'h0, rvalid}, 32'h0);
    check("rst.err",    {31'h0, err},    32'h0);
    check("rst.rdata",  rdata,           32'h0);

    // Clear phase with a load request held high the whole time: ignored.
    rst = 1'b0;
    req = 1'b1; we = 1'b0; size = 2'b10; addr = 9'h1FC;
    wait_ready("clear1", n, pulse);

    // Cleared top word
    step("ld_1fc", 1, 0, 2'b10, 0, 9'h1FC, 32'h0, 1, 32'h0000_0000);
    step("idle0",  0, 0, 2'b10, 0, 9'h000, 32'h0, 1, 32'h0);

    // Byte store and loads
    step("sb_013",  1, 1, 2'b00, 0, 9'h013, 32'hFFFF_FF80, 1, 32'h0);
    step("lb_013",  1, 0, 2'b00, 0, 9'h013, 32'h0, 1, 32'hFFFF_FF80);
    step("lbu_013", 1, 0, 2'b00, 1, 9'h013, 32'h0, 1, 32'h0000_0080);
    step("lw_010",  1, 0, 2'b10, 0, 9'h010, 32'h0, 1, 32'h8000_0000);
    step("hold",    0, 0, 2'b10, 0, 9'h000, 32'h0, 1, 32'h0);

    // Halfword store over a word
    step("sw_020",  1, 1, 2'b10, 0, 9'h020, 32'h1122_3344, 1, 32'h0);
    step("sh_022",  1, 1, 2'b01, 0, 9'h022, 32'h1234_BEEF, 1, 32'h0);
    step("lw_020",  1, 0, 2'b10, 0, 9'h020, 32'h0, 1, 32'hBEEF_3344);
    step("lh_022",  1, 0, 2'b01, 0, 9'h022, 32'h0, 1, 32'hFFFF_BEEF);
    step("lhu_020", 1, 0, 2'b01, 1, 9'h020, 32'h0, 1, 32'h0000_3344);
    step("lb_021",  1, 0, 2'b00, 0, 9'h021, 32'h0, 1, 32'h0000_0033);
    step("lwu_020", 1, 0, 2'b10, 1, 9'h020, 32'h0, 1, 32'hBEEF_3344);

    // Misalignment and reserved size
    step("sw_030",  1, 1, 2'b10, 0, 9'h030, 32'h5566_7788, 1, 32'h0);
    step("sw_031",  1, 1, 2'b10, 0, 9'h031, 32'hDEAD_BEEF, 1, 32'h0);
    step("lw_030",  1, 0, 2'b10, 0, 9'h030, 32'h0, 1, 32'h5566_7788);
    step("lh_031",  1, 0, 2'b01, 0, 9'h031, 32'h0, 1, 32'h0);
    step("lw_030b", 1, 0, 2'b10, 0, 9'h030, 32'h0, 1, 32'h5566_7788);
    step("lx_030",  1, 0, 2'b11, 0, 9'h030, 32'h0, 1, 32'h0);
    step("sh_033",  1, 1, 2'b01, 0, 9'h033, 32'h0000_FFFF, 1, 32'h0);
    step("lw_030c", 1, 0, 2'b10, 0, 9'h030, 32'h0, 1, 32'h5566_7788);

    // Store then load in consecutive cycles, then back-to-back loads
    step("sw_040",  1, 1, 2'b10, 0, 9'h040, 32'hCAFE_F00D, 1, 32'h0);
    step("lw_040",  1, 0, 2'b10, 0, 9'h040, 32'h0, 1, 32'hCAFE_F00D);
    step("lbu_042", 1, 0, 2'b00, 1, 9'h042, 32'h0, 1, 32'h0000_00FE);
    step("lh_040",  1, 0, 2'b01, 0, 9'h040, 32'h0, 1, 32'hFFFF_F00D);
    step("idle1",   0, 0, 2'b10, 0, 9'h000, 32'h0, 1, 32'h0);

    // Reset mid-clear: pre-write a word, reset, abort clear at count 50
    step("sw_100",  1, 1, 2'b10, 0, 9'h100, 32'h1234_5678, 1, 32'h0);
    rst = 1'b1;
    #1;
    check("rst2.ready",  {31'h0, ready},  32'h0);
    check("rst2.rvalid", {31'h0, rvalid}, 32'h0);
    check("rst2.rdata",  rdata,           32'h0);
    last_rdata = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    repeat (50) @(posedge clk);
    #2;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    req = 1'b1; we = 1'b1; size = 2'b10; addr = 9'h100; wdata = 32'hFFFF_FFFF;
    wait_ready("clear2", n, pulse);
    step("lw_100",  1, 0, 2'b10, 0, 9'h100, 32'h0, 1, 32'h0000_0000);
    step("idle2",   0, 0, 2'b10, 0, 9'h000, 32'h0, 1, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
